// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared encodings and constants for the LED controller
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'b00,
        MODE_SLOW  = 2'b01,
        MODE_FAST  = 2'b10,
        MODE_HEART = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int COLOR_GREEN_BIT = 0;
    localparam int COLOR_RED_BIT   = 1;

    localparam int PHASE_W      = 10;
    localparam int PH_SLOW_BIT  = 9;
    localparam int PH_FAST_BIT  = 7;
    localparam int PH_HEART_MSB = 9;
    localparam int PH_HEART_LSB = 6;

endpackage

// File: rtl/led_ctrl_if.sv
// rtl/led_ctrl_if.sv - requester bus: level requests, mode/colour lanes, one-hot grant
interface led_ctrl_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   i_req;
    logic [2*N_REQ-1:0] i_mode;
    logic [2*N_REQ-1:0] i_color;
    logic [N_REQ-1:0]   o_grant;

    modport master (output i_req, output i_mode, output i_color, input  o_grant);
    modport slave  (input  i_req, input  i_mode, input  i_color, output o_grant);
endinterface

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - millisecond prescaler and free-running 10-bit blink phase
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 48000
) (
    input  logic               i_ifclk,
    input  logic               i_rst_n,
    output logic               o_tick,
    output logic [PHASE_W-1:0] o_phase
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0]   r_cnt;
    logic [PHASE_W-1:0] r_phase;
    logic               w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));

    // Phase is only ever cleared by reset so all blink patterns stay globally aligned.
    always_ff @(posedge i_ifclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= '0;
        end else begin
            if (w_wrap) begin
                r_cnt   <= '0;
                r_phase <= r_phase + 1'b1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tick  = w_wrap;
    assign o_phase = r_phase;
endmodule

// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - fixed-priority LED owner arbitration with minimum hold,
// blink patterns and per-colour activity flash overlay; drives active-low pads.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 48000,
    parameter int N_REQ       = 4,
    parameter int MIN_HOLD_MS = 100,
    parameter int ACT_MS      = 30
) (
    input  logic       i_ifclk,
    input  logic       i_rst_n,
    led_ctrl_if.slave  io_bus,
    input  logic       i_act_green,
    input  logic       i_act_red,
    output logic       o_led_green,
    output logic       o_led_red
);
    localparam int OW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = (MIN_HOLD_MS > 0) ? $clog2(MIN_HOLD_MS + 1) : 1;
    localparam int ACT_W  = (ACT_MS > 0) ? $clog2(ACT_MS + 1) : 1;

    logic               w_tick;
    logic [PHASE_W-1:0] w_phase;
    logic               w_phase_unused;

    state_e             r_state, w_state_n;
    logic [OW-1:0]      r_owner, w_owner_n;
    logic [HOLD_W-1:0]  r_hold, w_hold_n;
    logic [1:0]         r_mode, w_mode_n;
    logic [1:0]         r_color, w_color_n;
    logic [N_REQ-1:0]   r_grant, w_grant_n;
    logic [ACT_W-1:0]   r_act_g, r_act_r;
    logic               r_led_g, r_led_r;

    logic               w_any;
    logic [OW-1:0]      w_lowest;
    logic               w_owner_req;
    logic               w_expired;
    logic               w_pattern;
    logic               w_on_g, w_on_r;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .i_ifclk (i_ifclk),
        .i_rst_n (i_rst_n),
        .o_tick  (w_tick),
        .o_phase (w_phase)
    );

    assign w_phase_unused = ^{w_phase[PH_HEART_LSB-1:0], w_phase[8]};

    always_comb begin
        w_any    = |io_bus.i_req;
        w_lowest = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (io_bus.i_req[i]) w_lowest = OW'(i);
        end
    end

    assign w_owner_req = io_bus.i_req[r_owner];
    // Hold saturates, so comparing the pre-increment value is stable across a tick.
    assign w_expired   = (r_hold == HOLD_W'(MIN_HOLD_MS));

    always_comb begin
        w_state_n = r_state;
        w_owner_n = r_owner;
        w_hold_n  = r_hold;
        w_mode_n  = r_mode;
        w_color_n = r_color;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_n = ST_GRANT;
                    w_owner_n = w_lowest;
                    w_hold_n  = '0;
                    w_mode_n  = io_bus.i_mode[{w_lowest, 1'b0} +: 2];
                    w_color_n = io_bus.i_color[{w_lowest, 1'b0} +: 2];
                end
            end
            ST_GRANT: begin
                if (w_tick && !w_expired) w_hold_n = r_hold + 1'b1;
                if (w_owner_req) begin
                    w_mode_n  = io_bus.i_mode[{r_owner, 1'b0} +: 2];
                    w_color_n = io_bus.i_color[{r_owner, 1'b0} +: 2];
                end
                if (w_expired) begin
                    if (w_any && (w_lowest < r_owner || !w_owner_req)) begin
                        w_owner_n = w_lowest;
                        w_hold_n  = '0;
                        w_mode_n  = io_bus.i_mode[{w_lowest, 1'b0} +: 2];
                        w_color_n = io_bus.i_color[{w_lowest, 1'b0} +: 2];
                    end else if (!w_owner_req) begin
                        w_state_n = ST_IDLE;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        w_grant_n = (w_state_n == ST_GRANT) ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_owner_n) : '0;
    end

    always_ff @(posedge i_ifclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_hold  <= '0;
            r_mode  <= '0;
            r_color <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_n;
            r_owner <= w_owner_n;
            r_hold  <= w_hold_n;
            r_mode  <= w_mode_n;
            r_color <= w_color_n;
            r_grant <= w_grant_n;
        end
    end

    // A new pulse always reloads, so back-to-back activity extends the flash.
    always_ff @(posedge i_ifclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_g <= '0;
            r_act_r <= '0;
        end else begin
            if (i_act_green)                  r_act_g <= ACT_W'(ACT_MS);
            else if (w_tick && r_act_g != '0) r_act_g <= r_act_g - 1'b1;
            if (i_act_red)                    r_act_r <= ACT_W'(ACT_MS);
            else if (w_tick && r_act_r != '0) r_act_r <= r_act_r - 1'b1;
        end
    end

    always_comb begin
        w_pattern = 1'b0;
        case (mode_e'(r_mode))
            MODE_SOLID: w_pattern = 1'b1;
            MODE_SLOW:  w_pattern = w_phase[PH_SLOW_BIT];
            MODE_FAST:  w_pattern = w_phase[PH_FAST_BIT];
            MODE_HEART: w_pattern = (w_phase[PH_HEART_MSB:PH_HEART_LSB] == 4'd0) ||
                                    (w_phase[PH_HEART_MSB:PH_HEART_LSB] == 4'd2);
            default:    w_pattern = 1'b0;
        endcase
    end

    assign w_on_g = ((r_state == ST_GRANT) & r_color[COLOR_GREEN_BIT] & w_pattern) ^ (r_act_g != '0);
    assign w_on_r = ((r_state == ST_GRANT) & r_color[COLOR_RED_BIT]   & w_pattern) ^ (r_act_r != '0);

    always_ff @(posedge i_ifclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_led_g <= 1'b1;
            r_led_r <= 1'b1;
        end else begin
            r_led_g <= ~w_on_g;
            r_led_r <= ~w_on_r;
        end
    end

    assign io_bus.o_grant = r_grant;
    assign o_led_green    = r_led_g;
    assign o_led_red      = r_led_r;
endmodule

// File: tb/tb_led_ctrl.sv
// tb/tb_led_ctrl.sv - directed vector table plus multi-cycle sequences for led_ctrl
module tb_led_ctrl;
    localparam int TD = 4;
    localparam int NR = 4;
    localparam int MH = 3;
    localparam int AM = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic act_g = 1'b0;
    logic act_r = 1'b0;
    logic led_g, led_r;

    led_ctrl_if #(.N_REQ(NR)) bus ();

    led_ctrl #(.TICK_DIV(TD), .N_REQ(NR), .MIN_HOLD_MS(MH), .ACT_MS(AM)) dut (
        .i_ifclk     (clk),
        .i_rst_n     (rst_n),
        .io_bus      (bus),
        .i_act_green (act_g),
        .i_act_red   (act_r),
        .o_led_green (led_g),
        .o_led_red   (led_r)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference prescaler, phase and stretch behaviour; *_d are the values seen by the LED register.
    int         m_div, m_phase, m_act_g, m_act_r;
    logic [9:0] m_ph_d;
    logic       m_ag_d, m_ar_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div <= 0; m_phase <= 0; m_act_g <= 0; m_act_r <= 0;
            m_ph_d <= '0; m_ag_d <= 1'b0; m_ar_d <= 1'b0;
        end else begin
            m_ph_d <= m_phase[9:0];
            m_ag_d <= (m_act_g != 0);
            m_ar_d <= (m_act_r != 0);
            m_div  <= (m_div == TD - 1) ? 0 : m_div + 1;
            if (m_div == TD - 1) m_phase <= (m_phase + 1) % 1024;
            if (act_g) m_act_g <= AM;
            else if (m_div == TD - 1 && m_act_g > 0) m_act_g <= m_act_g - 1;
            if (act_r) m_act_r <= AM;
            else if (m_div == TD - 1 && m_act_r > 0) m_act_r <= m_act_r - 1;
        end
    end

    typedef struct {
        logic [3:0] req;
        logic [7:0] mode;
        logic [7:0] color;
        logic [3:0] grant;
        logic       lg;
        logic       lr;
    } vec_t;

    vec_t vt[20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [7:0] m, input logic [7:0] c);
        bus.i_req   = r;
        bus.i_mode  = m;
        bus.i_color = c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        int sw;
        logic [3:0] exp_g;

        vt[0]  = '{4'b0000, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b1};
        vt[1]  = '{4'b0000, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b1};
        vt[2]  = '{4'b0100, 8'h00, 8'h10, 4'b0100, 1'b1, 1'b1};
        vt[3]  = '{4'b0100, 8'h00, 8'h10, 4'b0100, 1'b0, 1'b1};
        vt[4]  = '{4'b0100, 8'h00, 8'h10, 4'b0100, 1'b0, 1'b1};
        vt[5]  = '{4'b0100, 8'h00, 8'h20, 4'b0100, 1'b0, 1'b1};
        vt[6]  = '{4'b0100, 8'h00, 8'h20, 4'b0100, 1'b1, 1'b0};
        vt[7]  = '{4'b0100, 8'h00, 8'h30, 4'b0100, 1'b1, 1'b0};
        vt[8]  = '{4'b0100, 8'h00, 8'h30, 4'b0100, 1'b0, 1'b0};
        vt[9]  = '{4'b1100, 8'h00, 8'h30, 4'b0100, 1'b0, 1'b0};
        vt[10] = '{4'b0100, 8'h10, 8'h30, 4'b0100, 1'b0, 1'b0};
        vt[11] = '{4'b0100, 8'h10, 8'h30, 4'b0100, 1'b1, 1'b1};
        vt[12] = '{4'b0100, 8'h30, 8'h30, 4'b0100, 1'b1, 1'b1};
        vt[13] = '{4'b0100, 8'h30, 8'h30, 4'b0100, 1'b0, 1'b0};
        vt[14] = '{4'b0100, 8'h20, 8'h30, 4'b0100, 1'b0, 1'b0};
        vt[15] = '{4'b0100, 8'h20, 8'h30, 4'b0100, 1'b1, 1'b1};
        vt[16] = '{4'b0100, 8'h00, 8'h30, 4'b0100, 1'b1, 1'b1};
        vt[17] = '{4'b0100, 8'h00, 8'h30, 4'b0100, 1'b0, 1'b0};
        vt[18] = '{4'b0000, 8'h00, 8'h30, 4'b0000, 1'b0, 1'b0};
        vt[19] = '{4'b0000, 8'h00, 8'h30, 4'b0000, 1'b1, 1'b1};

        drive(4'b0000, 8'h00, 8'h00);
        repeat (5) step();
        check("rst_grant", bus.o_grant, 4'b0000);
        check("rst_led_g", led_g, 1'b1);
        check("rst_led_r", led_r, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].req, vt[i].mode, vt[i].color);
            step();
            check($sformatf("vec%0d_grant", i), bus.o_grant, vt[i].grant);
            check($sformatf("vec%0d_led_g", i), led_g, vt[i].lg);
            check($sformatf("vec%0d_led_r", i), led_r, vt[i].lr);
        end

        // Owner 3 (solid green) held against a higher-priority red request.
        drive(4'b1000, 8'h00, 8'h42);
        step();
        check("hold_first_grant", bus.o_grant, 4'b1000);
        drive(4'b1001, 8'h00, 8'h42);
        nt = 0;
        sw = -1;
        for (int i = 0; i < 24; i++) begin
            exp_g = (sw >= 0 || nt >= MH) ? 4'b0001 : 4'b1000;
            step();
            check("hold_grant", bus.o_grant, exp_g);
            if (sw < 0 && nt >= MH) sw = i;
            if (i == 0) check("hold_owner3_green", led_g, 1'b0);
            if (sw >= 0 && i == sw + 1) begin
                check("preempt_led_g", led_g, 1'b1);
                check("preempt_led_r", led_r, 1'b0);
            end
            if (m_div == 0) nt++;
        end
        check("hold_switched", (sw >= 0), 1'b1);

        drive(4'b0001, 8'h00, 8'h42);
        repeat (16) step();
        drive(4'b0000, 8'h00, 8'h42);
        step();
        check("drop_idle_grant", bus.o_grant, 4'b0000);
        step();
        check("drop_idle_led_g", led_g, 1'b1);
        check("drop_idle_led_r", led_r, 1'b1);
        drive(4'b0010, 8'h00, 8'h00);
        step();
        check("grant_req1", bus.o_grant, 4'b0010);
        repeat (16) step();
        drive(4'b1000, 8'h00, 8'h00);
        step();
        check("drop_to_req3", bus.o_grant, 4'b1000);
        drive(4'b0000, 8'h00, 8'h00);
        repeat (16) step();
        check("back_idle", bus.o_grant, 4'b0000);

        // Activity flashes in IDLE, including a retrigger mid-flash.
        act_r = 1'b1;
        step();
        act_r = 1'b0;
        step();
        check("act_idle_red_on", led_r, 1'b0);
        for (int i = 0; i < 30; i++) begin
            act_r = (i == 3);
            act_g = (i == 14);
            step();
            check("act_idle_red", led_r, !m_ar_d);
            check("act_idle_green", led_g, !m_ag_d);
        end
        act_r = 1'b0;
        act_g = 1'b0;

        // Under a solid red owner the flash turns the LED off.
        drive(4'b0010, 8'h00, 8'h08);
        step();
        step();
        check("red_owner_on", led_r, 1'b0);
        check("red_owner_green_off", led_g, 1'b1);
        act_r = 1'b1;
        act_g = 1'b1;
        step();
        act_r = 1'b0;
        act_g = 1'b0;
        step();
        check("red_owner_flash_off", led_r, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("red_owner_red", led_r, m_ar_d);
            check("red_owner_green", led_g, !m_ag_d);
        end
        check("red_owner_back_on", led_r, 1'b0);

        // Asynchronous reset mid-operation.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", bus.o_grant, 4'b0000);
        check("async_rst_led_r", led_r, 1'b1);
        check("async_rst_led_g", led_g, 1'b1);
        step();
        step();
        rst_n = 1'b1;

        // Fast blink from a fresh phase; owner change midway must not disturb it.
        drive(4'b0010, 8'h08, 8'h04);
        for (int i = 0; i < 1400; i++) begin
            if (i == 700) drive(4'b0011, 8'h0A, 8'h05);
            step();
            if (i == 0)   check("blink_grant1", bus.o_grant, 4'b0010);
            if (i == 700) check("blink_grant0", bus.o_grant, 4'b0001);
            if (i >= 1) begin
                check("blink_green", led_g, !m_ph_d[7]);
                check("blink_red", led_r, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
